store_buffer: RTL
=================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 memWriteM  in  1  store instruction in M stage.
REQ-005 memReadM  in  1  load instruction in M stage; never asserted together with memWriteM.
REQ-006 data_ram_waddrM  in  32  byte address of the M-stage load/store; bits [1:0] ignored (word access only).
REQ-007 data_ram_wdataM  in  32  store data.
REQ-008 data_ram_rdataM  out  32  load result to the datapath W-stage register.
REQ-009 stallM  out  1  datapath SHALL hold F..M while high; M-stage inputs are held stable.
REQ-010 mem_req  out  1  memory request valid.
REQ-011 mem_we  out  1  1 = write (drain), 0 = read (load).
REQ-012 mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-013 mem_wdata  out  32  write data.
REQ-014 mem_gnt  in  1  request accepted when mem_req & mem_gnt in the same cycle.
REQ-015 mem_rvalid  in  1  read data valid; exactly one pulse per granted read, no earlier than the cycle after grant.
REQ-016 mem_rdata  in  32  read data.
REQ-017 sb_empty  out  1  buffer holds no stores and no request is outstanding.

Function
REQ-018 Storage is a circular FIFO of DEPTH {word address, data} entries with head/tail pointers and a count of width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-019 Store push: memWriteM=1 and count<DEPTH at cycle start -> entry written at tail, stallM=0; push is independent of FSM state.
REQ-020 Full: memWriteM=1 and count==DEPTH -> stallM=1 and no push, even if a drain completes that cycle; the push happens the next cycle.
REQ-021 Load hit: memReadM=1 and word address matches any valid entry -> data_ram_rdataM = data of the youngest matching entry, combinationally, stallM=0, in any FSM state.
REQ-022 Load miss -> stallM=1 until the LD_DONE cycle; the load never reads memory ahead of a same-address store still buffered.
REQ-023 FSM states: IDLE, DRAIN, LD_REQ, LD_WAIT, LD_DONE.
REQ-024 IDLE: load miss -> LD_REQ; else count>0 -> DRAIN; else stay.
REQ-025 DRAIN: mem_req=1, mem_we=1, addr/data from head; on mem_gnt pop head and go to IDLE; once raised, the request is held unchanged until granted.
REQ-026 Load miss during DRAIN: stallM=1 and the read waits for the write grant (IDLE, then LD_REQ).
REQ-027 LD_REQ: mem_req=1, mem_we=0, mem_addr = load address; on mem_gnt go to LD_WAIT.
REQ-028 LD_WAIT: on mem_rvalid capture mem_rdata into a register and go to LD_DONE.
REQ-029 LD_DONE: one cycle, stallM=0, data_ram_rdataM = captured register, then IDLE.
REQ-030 The lowest latency for a load miss is 3 stall cycles: LD_REQ granted at once, rvalid on the next cycle, and release in LD_DONE.
REQ-031 mem_req=0 in IDLE, LD_WAIT and LD_DONE; mem_addr/mem_wdata hold their last value when idle.
REQ-032 data_ram_rdataM = 0 when no load is active and not in LD_DONE.
REQ-033 sb_empty = (count==0) & (state==IDLE).

Reset
REQ-034 Asserting rst clears count, head and tail immediately and discards buffered stores.
REQ-035 Asserting rst forces state=IDLE; stallM, mem_req, mem_we, sb_empty-inverse, data_ram_rdataM, mem_addr and mem_wdata are all 0 while rst=0.
REQ-036 Reset mid-request drops mem_req in the same cycle; a late mem_rvalid after reset is ignored.

Structure
REQ-037 A shared package holds the DEPTH default, the state enumeration and the entry record {addr[29:0], data[31:0]}.
REQ-038 One sub-module, store_fifo, SHALL hold the storage, pointers, count and the youngest-match address lookup; the FSM and port muxing stay in store_buffer.

Verification
REQ-039 Push 0x10<-0xAAAA0001 with mem_gnt=1 -> the cycle after the push mem_req=1, mem_we=1, mem_addr=0x10, mem_wdata=0xAAAA0001; sb_empty=1 two cycles after the push.
REQ-040 mem_gnt=0 and 5 stores to 0x0,0x4,0x8,0xC,0x10 -> stallM=1 on the 5th; after one grant the 0x10 store is pushed on the next cycle and count=4.
REQ-041 Stores 0x20<-1 then 0x20<-2 (gnt=0), then load 0x20 -> data_ram_rdataM=2 with stallM=0 in the same cycle.
REQ-042 Load 0x40 miss with gnt=1 and rvalid 2 cycles after grant, rdata=0xDEADBEEF -> stallM high for 4 cycles, then data_ram_rdataM=0xDEADBEEF with stallM=0.
REQ-043 Load miss while a DRAIN is ungranted for 3 cycles -> the write is issued first, then the read; stallM stays high throughout.
REQ-044 rst=0 during LD_WAIT with 2 buffered stores -> mem_req=0, stallM=0 and sb_empty=1 after release, and a later rvalid does not change the outputs.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: default depth, FSM state encoding and
// the buffered-store record.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    LD_REQ,
    LD_WAIT,
    LD_DONE
  } sbState_t;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } sbEntry_t;

endpackage

// File: rtl/store_fifo.sv
// Circular FIFO of buffered stores with a youngest-match lookup used to
// forward store data to loads.
module store_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  sbEntry_t      pushEntry,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic          full,
  output sbEntry_t      headEntry,
  input  logic [29:0]   lookupAddr,
  output logic          lookupHit,
  output logic [31:0]   lookupData
);

  sbEntry_t      storage [DEPTH];
  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;
  logic [PW-1:0] scanIdx;

  assign full      = (count == CW'(DEPTH));
  assign headEntry = storage[headPtr];

  // NOTE: the storage array has no reset; count alone decides which entries
  // are valid, so clearing the pointers is enough to discard everything.
  always_ff @(posedge clk) begin
    if (push) begin
      storage[tailPtr] <= pushEntry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (push) tailPtr <= tailPtr + 1'b1;
      if (pop)  headPtr <= headPtr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Scan oldest to youngest so the last match seen is the youngest store.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    lookupHit  = 1'b0;
    lookupData = '0;
    scanIdx    = headPtr;
    for (int i = 0; i < DEPTH; i++) begin
      scanIdx = headPtr + PW'(i);
      if ((CW'(i) < count) && (storage[scanIdx].addr == lookupAddr)) begin
        lookupHit  = 1'b1;
        lookupData = storage[scanIdx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the M stage and a single-port memory: buffers stores,
// forwards them to loads, drains them in order and services load misses.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memWriteM,
  input  logic        memReadM,
  input  logic [31:0] data_ram_waddrM,
  input  logic [31:0] data_ram_wdataM,
  output logic [31:0] data_ram_rdataM,
  output logic        stallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        sb_empty
);

  localparam int CW = $clog2(DEPTH) + 1;

  sbState_t      state;
  sbState_t      nextState;
  logic [CW-1:0] count;
  logic          full;
  logic          lookupHit;
  logic [31:0]   lookupData;
  sbEntry_t      headEntry;
  sbEntry_t      pushEntry;
  logic          pushReq;
  logic          popReq;
  logic          loadMiss;
  logic          memReq;
  logic          memWe;
  logic          capture;
  logic [29:0]   wordAddr;
  logic [29:0]   reqAddr;
  logic [29:0]   lastAddr;
  logic [31:0]   reqData;
  logic [31:0]   lastData;
  logic [31:0]   loadData;
  logic          unusedByteOffset;

  assign wordAddr         = data_ram_waddrM[31:2];
  assign unusedByteOffset = ^data_ram_waddrM[1:0];
  assign pushEntry        = '{addr: wordAddr, data: data_ram_wdataM};
  assign pushReq          = memWriteM & ~full;
  assign popReq           = (state == DRAIN) & mem_gnt;
  assign loadMiss         = memReadM & ~lookupHit;

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (pushReq),
    .pushEntry  (pushEntry),
    .pop        (popReq),
    .count      (count),
    .full       (full),
    .headEntry  (headEntry),
    .lookupAddr (wordAddr),
    .lookupHit  (lookupHit),
    .lookupData (lookupData)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // Loads win over draining in IDLE: a miss implies no same-address store
  // is buffered, so reading memory first cannot bypass a pending write.
  always_comb begin
    nextState = state;
    memReq    = 1'b0;
    memWe     = 1'b0;
    reqAddr   = lastAddr;
    reqData   = lastData;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (loadMiss)                        nextState = LD_REQ;
        else if ((count != '0) || pushReq)   nextState = DRAIN;
      end
      DRAIN: begin
        memReq  = 1'b1;
        memWe   = 1'b1;
        reqAddr = headEntry.addr;
        reqData = headEntry.data;
        if (mem_gnt) nextState = IDLE;
      end
      LD_REQ: begin
        memReq  = 1'b1;
        reqAddr = wordAddr;
        if (mem_gnt) nextState = LD_WAIT;
      end
      LD_WAIT: begin
        if (mem_rvalid) begin
          capture   = 1'b1;
          nextState = LD_DONE;
        end
      end
      LD_DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // The bus address/data registers keep the last request visible when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastAddr <= '0;
      lastData <= '0;
      loadData <= '0;
    end else begin
      if (memReq) begin
        lastAddr <= reqAddr;
        lastData <= reqData;
      end
      if (capture) loadData <= mem_rdata;
    end
  end

  always_comb begin
    data_ram_rdataM = '0;
    if (state == LD_DONE)              data_ram_rdataM = loadData;
    else if (memReadM && lookupHit)    data_ram_rdataM = lookupData;
  end

  assign stallM    = rst & ((memWriteM & full) | (loadMiss & (state != LD_DONE)));
  assign mem_req   = memReq;
  assign mem_we    = memWe;
  assign mem_addr  = {reqAddr, 2'b00};
  assign mem_wdata = reqData;
  assign sb_empty  = (count == '0) && (state == IDLE);

endmodule
